// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, instruction field positions and reset PC for the multicycle MIPS datapath.
package mips_pkg;
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_SLT  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_t;
  typedef enum logic [1:0] {
    SRCB_B    = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_IMM4 = 2'b11
  } srcb_t;
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one sync write port, $0 hardwired to zero.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0)
      regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/mips_multicycle_datapath.sv
// mips_multicycle_datapath: PC/IR/MDR/A/B/ALUOut state, inline ALU and muxes, register file,
// driven each cycle by the control unit's strobes; single unified memory port.
module mips_multicycle_datapath
  import mips_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IorD,
  input  logic             Mem_Write,
  input  logic             IR_Write,
  input  logic             PC_Write,
  input  logic             PC_Src,
  input  logic             Branch,
  input  logic             ALU_SrcA,
  input  logic             Reg_Write,
  input  logic             Mem_Reg,
  input  logic             Reg_Dst,
  input  logic [2:0]       ALU_Control,
  input  logic [1:0]       ALU_SrcB,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [5:0]       Op,
  output logic [5:0]       Funct,
  output logic [WIDTH-1:0] pc_dbg
);
  logic [WIDTH-1:0] pc, ir, mdr, a, b, alu_out;
  logic [WIDTH-1:0] rd1, rd2, src_a, src_b, result, sign_imm, pc_next;
  logic [4:0]       wa;
  logic             zero;
  assign sign_imm  = {{(WIDTH-16){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
  assign src_a     = ALU_SrcA ? a : pc;
  assign src_b     = ALU_SrcB == SRCB_B    ? b :
                     ALU_SrcB == SRCB_FOUR ? WIDTH'(4) :
                     ALU_SrcB == SRCB_IMM  ? sign_imm : sign_imm << 2;
  always_comb begin
    result = src_b;
    case (alu_op_t'(ALU_Control))
      ALU_AND: result = src_a & src_b;
      ALU_ADD: result = src_a + src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_NOR: result = ~(src_a | src_b);
      ALU_XOR: result = src_a ^ src_b;
      ALU_SUB: result = src_a - src_b;
      default: result = src_b;
    endcase
  end
  assign zero      = result == '0;
  assign pc_next   = PC_Src ? alu_out : result;
  assign wa        = Reg_Dst ? ir[RD_HI:RD_LO] : ir[RT_HI:RT_LO];
  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b;
  assign mem_we    = Mem_Write;
  assign Op        = ir[OP_HI:OP_LO];
  assign Funct     = ir[FUNCT_HI:FUNCT_LO];
  assign pc_dbg    = pc;
  // MDR/A/B/ALUOut are unconditional pipeline latches between the multicycle steps
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (IR_Write) ir <= mem_rdata;
      if (PC_Write | (Branch & zero)) pc <= pc_next;
      mdr     <= mem_rdata;
      a       <= rd1;
      b       <= rd2;
      alu_out <= result;
    end
  mips_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[RS_HI:RS_LO]),
    .ra2 (ir[RT_HI:RT_LO]),
    .wa  (wa),
    .we  (Reg_Write),
    .wd  (Mem_Reg ? mdr : alu_out),
    .rd1 (rd1),
    .rd2 (rd2)
  );
endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// tb_mips_multicycle_datapath: directed instruction sequences through the datapath, observing
// registers through B (mem_wdata) and ALUOut (mem_addr with IorD=1).
module tb_mips_multicycle_datapath;
  typedef struct packed {
    logic iord, mw, irw, pcw, pcs, br, sa, rw, mr, rd;
    logic [2:0] alu;
    logic [1:0] sb;
  } ctl_t;
  typedef struct {
    ctl_t        c;
    logic [31:0] rd, pc, addr, wdata;
    logic        we;
    logic [5:0]  op, funct;
  } vec_t;
  logic        clk = 0, rst = 1;
  logic        IorD, Mem_Write, IR_Write, PC_Write, PC_Src, Branch, ALU_SrcA, Reg_Write, Mem_Reg, Reg_Dst;
  logic [2:0]  ALU_Control;
  logic [1:0]  ALU_SrcB;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, pc_dbg;
  logic        mem_we;
  logic [5:0]  Op, Funct;
  int          n_cmp = 0, n_bad = 0;
  mips_multicycle_datapath dut (
    .clk(clk), .rst(rst), .IorD(IorD), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .PC_Src(PC_Src), .Branch(Branch), .ALU_SrcA(ALU_SrcA),
    .Reg_Write(Reg_Write), .Mem_Reg(Mem_Reg), .Reg_Dst(Reg_Dst), .ALU_Control(ALU_Control),
    .ALU_SrcB(ALU_SrcB), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .Op(Op), .Funct(Funct), .pc_dbg(pc_dbg)
  );
  always #5 clk = ~clk;
  function automatic ctl_t cw(logic iord, mw, irw, pcw, pcs, br, sa, rw, mr, rd,
                              logic [2:0] alu, logic [1:0] sb);
    return {iord, mw, irw, pcw, pcs, br, sa, rw, mr, rd, alu, sb};
  endfunction
  function automatic vec_t mk(ctl_t c, logic [31:0] rd, pc, addr, wdata, logic we,
                              logic [5:0] op, funct);
    vec_t v;
    v.c = c; v.rd = rd; v.pc = pc; v.addr = addr; v.wdata = wdata;
    v.we = we; v.op = op; v.funct = funct;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  task automatic apply(ctl_t c, logic [31:0] rd);
    IorD = c.iord; Mem_Write = c.mw; IR_Write = c.irw; PC_Write = c.pcw; PC_Src = c.pcs;
    Branch = c.br; ALU_SrcA = c.sa; Reg_Write = c.rw; Mem_Reg = c.mr; Reg_Dst = c.rd;
    ALU_Control = c.alu; ALU_SrcB = c.sb; mem_rdata = rd;
  endtask
  // checks are pre-edge: they see state from earlier edges under this step's controls
  task automatic step(string tag, vec_t v);
    apply(v.c, v.rd);
    #1;
    chk({tag, " pc"}, pc_dbg, v.pc);
    chk({tag, " addr"}, mem_addr, v.addr);
    chk({tag, " wdata"}, mem_wdata, v.wdata);
    chk({tag, " we"}, {31'd0, mem_we}, {31'd0, v.we});
    chk({tag, " op"}, {26'd0, Op}, {26'd0, v.op});
    chk({tag, " funct"}, {26'd0, Funct}, {26'd0, v.funct});
    @(posedge clk);
    #1;
  endtask
  ctl_t FETCH, DEC, EXI, EXR, WBI, WBR, MEM, WBM, MEMW, BEQ, IDLE;
  vec_t tbl[$];
  vec_t post[$];
  logic        sw_sa[13];
  logic [1:0]  sw_sb[13];
  logic [2:0]  sw_alu[13];
  logic [31:0] sw_exp[13];
  initial begin
    FETCH = cw(0,0,1,1,0,0,0,0,0,0,3'b001,2'b01);
    DEC   = cw(0,0,0,0,0,0,0,0,0,0,3'b001,2'b11);
    EXI   = cw(0,0,0,0,0,0,1,0,0,0,3'b001,2'b10);
    EXR   = cw(0,0,0,0,0,0,1,0,0,0,3'b001,2'b00);
    WBI   = cw(1,0,0,0,0,0,0,1,0,0,3'b000,2'b00);
    WBR   = cw(1,0,0,0,0,0,0,1,0,1,3'b000,2'b00);
    MEM   = cw(1,0,0,0,0,0,1,0,0,0,3'b001,2'b10);
    WBM   = cw(1,0,0,0,0,0,0,1,1,0,3'b000,2'b00);
    MEMW  = cw(1,1,0,0,0,0,1,0,0,0,3'b001,2'b10);
    BEQ   = cw(0,0,0,0,1,1,1,0,0,0,3'b110,2'b00);
    IDLE  = '0;
    // addi $17,$0,5
    tbl.push_back(mk(FETCH, 32'h20110005, 32'h00400000, 32'h00400000, 32'h0, 0, 6'h00, 6'h00));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400004, 32'h00400004, 32'h0, 0, 6'h08, 6'h05));
    tbl.push_back(mk(EXI,   32'h0,        32'h00400004, 32'h00400004, 32'h0, 0, 6'h08, 6'h05));
    tbl.push_back(mk(WBI,   32'h0,        32'h00400004, 32'h00000005, 32'h0, 0, 6'h08, 6'h05));
    // addi $18,$0,-1
    tbl.push_back(mk(FETCH, 32'h2012FFFF, 32'h00400004, 32'h00400004, 32'h0, 0, 6'h08, 6'h05));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400008, 32'h00400008, 32'h5, 0, 6'h08, 6'h3F));
    tbl.push_back(mk(EXI,   32'h0,        32'h00400008, 32'h00400008, 32'h0, 0, 6'h08, 6'h3F));
    tbl.push_back(mk(WBI,   32'h0,        32'h00400008, 32'hFFFFFFFF, 32'h0, 0, 6'h08, 6'h3F));
    // add $16,$17,$18
    tbl.push_back(mk(FETCH, 32'h02328020, 32'h00400008, 32'h00400008, 32'h0, 0, 6'h08, 6'h3F));
    tbl.push_back(mk(DEC,   32'h0,        32'h0040000C, 32'h0040000C, 32'hFFFFFFFF, 0, 6'h00, 6'h20));
    tbl.push_back(mk(EXR,   32'h0,        32'h0040000C, 32'h0040000C, 32'hFFFFFFFF, 0, 6'h00, 6'h20));
    tbl.push_back(mk(WBR,   32'h0,        32'h0040000C, 32'h00000004, 32'hFFFFFFFF, 0, 6'h00, 6'h20));
    // addi $8,$16,-2
    tbl.push_back(mk(FETCH, 32'h2208FFFE, 32'h0040000C, 32'h0040000C, 32'hFFFFFFFF, 0, 6'h00, 6'h20));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400010, 32'h00400010, 32'hFFFFFFFF, 0, 6'h08, 6'h3E));
    tbl.push_back(mk(EXI,   32'h0,        32'h00400010, 32'h00400010, 32'h0, 0, 6'h08, 6'h3E));
    tbl.push_back(mk(WBI,   32'h0,        32'h00400010, 32'h00000002, 32'h0, 0, 6'h08, 6'h3E));
    // addi $0,$0,7
    tbl.push_back(mk(FETCH, 32'h20000007, 32'h00400010, 32'h00400010, 32'h0, 0, 6'h08, 6'h3E));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400014, 32'h00400014, 32'h2, 0, 6'h08, 6'h07));
    tbl.push_back(mk(EXI,   32'h0,        32'h00400014, 32'h00400014, 32'h0, 0, 6'h08, 6'h07));
    tbl.push_back(mk(WBI,   32'h0,        32'h00400014, 32'h00000007, 32'h0, 0, 6'h08, 6'h07));
    // lw $9,0($0); DEC step sees B=$0 after the discarded write
    tbl.push_back(mk(FETCH, 32'h8C090000, 32'h00400014, 32'h00400014, 32'h0, 0, 6'h08, 6'h07));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400018, 32'h00400018, 32'h0, 0, 6'h23, 6'h00));
    tbl.push_back(mk(EXI,   32'h0,        32'h00400018, 32'h00400018, 32'h0, 0, 6'h23, 6'h00));
    tbl.push_back(mk(MEM,   32'hDEADBEEF, 32'h00400018, 32'h00000000, 32'h0, 0, 6'h23, 6'h00));
    tbl.push_back(mk(WBM,   32'h12345678, 32'h00400018, 32'h00000000, 32'h0, 0, 6'h23, 6'h00));
    // sw $9,0x40($0)
    tbl.push_back(mk(FETCH, 32'hAC090040, 32'h00400018, 32'h00400018, 32'h0, 0, 6'h23, 6'h00));
    tbl.push_back(mk(DEC,   32'h0,        32'h0040001C, 32'h0040001C, 32'hDEADBEEF, 0, 6'h2B, 6'h00));
    tbl.push_back(mk(EXI,   32'h0,        32'h0040001C, 32'h0040001C, 32'hDEADBEEF, 0, 6'h2B, 6'h00));
    tbl.push_back(mk(MEMW,  32'h0,        32'h0040001C, 32'h00000040, 32'hDEADBEEF, 1, 6'h2B, 6'h00));
    // beq $9,$9,-4 (taken to 0x00400010)
    tbl.push_back(mk(FETCH, 32'h1129FFFC, 32'h0040001C, 32'h0040001C, 32'hDEADBEEF, 0, 6'h2B, 6'h00));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400020, 32'h00400020, 32'hDEADBEEF, 0, 6'h04, 6'h3C));
    tbl.push_back(mk(BEQ,   32'h0,        32'h00400020, 32'h00400020, 32'hDEADBEEF, 0, 6'h04, 6'h3C));
    // beq $9,$8,+16 (not taken)
    tbl.push_back(mk(FETCH, 32'h11280010, 32'h00400010, 32'h00400010, 32'hDEADBEEF, 0, 6'h04, 6'h3C));
    tbl.push_back(mk(DEC,   32'h0,        32'h00400014, 32'h00400014, 32'hDEADBEEF, 0, 6'h04, 6'h10));
    tbl.push_back(mk(BEQ,   32'h0,        32'h00400014, 32'h00400014, 32'h2, 0, 6'h04, 6'h10));
    tbl.push_back(mk(IDLE,  32'h0,        32'h00400014, 32'h00400014, 32'h2, 0, 6'h04, 6'h10));
    // after mid-instruction reset: add $8,$0,$8 reads back the cleared $8 via B
    post.push_back(mk(FETCH, 32'h00084020, 32'h00400000, 32'h00400000, 32'h0, 0, 6'h00, 6'h00));
    post.push_back(mk(DEC,   32'h0,        32'h00400004, 32'h00400004, 32'h0, 0, 6'h00, 6'h20));
    post.push_back(mk(IDLE,  32'h0,        32'h00400004, 32'h00400004, 32'h0, 0, 6'h00, 6'h20));
    // ALU sweep with A=$9=DEADBEEF, B=$8=2, PC=0x00400014, imm=0x0010
    sw_sa  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    sw_sb  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    sw_alu = '{0, 1, 2, 3, 4, 5, 6, 7, 3, 1, 1, 1, 6};
    sw_exp = '{32'h00000002, 32'hDEADBEF1, 32'hDEADBEEF, 32'h00000001, 32'h21524110,
               32'hDEADBEED, 32'hDEADBEED, 32'h00000002, 32'h00000000, 32'hDEADBEF3,
               32'hDEADBEFF, 32'hDEADBF2F, 32'h00400012};
    apply(IDLE, 32'h0);
    @(posedge clk);
    #4;
    rst = 0;
    #1;
    chk("reset pc", pc_dbg, 32'h00400000);
    chk("reset addr", mem_addr, 32'h00400000);
    chk("reset op", {26'd0, Op}, 32'h0);
    chk("reset funct", {26'd0, Funct}, 32'h0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < tbl.size(); i++) step($sformatf("s%0d", i + 1), tbl[i]);
    for (int i = 0; i < 13; i++) begin
      apply(cw(1,0,0,0,0,0,sw_sa[i],0,0,0,sw_alu[i],sw_sb[i]), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("alu%0d", i), mem_addr, sw_exp[i]);
    end
    chk("sweep pc", pc_dbg, 32'h00400014);
    apply(cw(0,0,0,0,0,0,1,0,0,0,3'b111,2'b00), 32'h0);
    @(posedge clk);
    #1;
    apply(cw(0,0,0,1,1,1,0,0,0,0,3'b000,2'b00), 32'h0);
    @(posedge clk);
    #1;
    chk("pcw+branch pc", pc_dbg, 32'h00000002);
    apply(cw(0,0,0,0,0,0,0,1,0,0,3'b000,2'b00), 32'h0);
    #2;
    rst = 0;
    #1;
    chk("midrst pc", pc_dbg, 32'h00400000);
    chk("midrst addr", mem_addr, 32'h00400000);
    chk("midrst wdata", mem_wdata, 32'h0);
    chk("midrst op", {26'd0, Op}, 32'h0);
    chk("midrst funct", {26'd0, Funct}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < post.size(); i++) step($sformatf("p%0d", i + 1), post[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
